// File: rtl/fft_8p_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fft_8p_pkg
// Purpose : Shared definitions for the 8-point FFT datapath. Used by the
//           input serial-to-parallel stage, the control FSM and the output
//           parallel-to-serial unloader.
// Contents: N_POINTS, IDX_W, unloader state enum, bitrev3 helper.
// Revision: 1.0 - initial release
// ============================================================================
package fft_8p_pkg;

  localparam int N_POINTS = 8;
  localparam int IDX_W    = 3;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Reverse the three index bits: natural order <-> bit-reversed FFT order.
  function automatic logic [IDX_W-1:0] bitrev3(input logic [IDX_W-1:0] k);
    return {k[0], k[1], k[2]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft_8p_p2s_out.sv
`default_nettype none
// ============================================================================
// Module  : fft_8p_p2s_out
// Purpose : Output parallel-to-serial unloader for the 8-point FFT. Captures
//           eight complex results on a load pulse and streams them one per
//           beat over valid/ready, optionally in bit-reversed slot order.
// Ports   : clk, reset (async, active-high)
//           load, in_re, in_im        - frame capture (slot j at j*DATA_W)
//           out_valid/out_ready       - stream handshake
//           out_re, out_im, out_idx   - current beat data and beat number
//           out_last                  - marks beat 7
//           busy, done, overrun       - status; clr_err clears overrun
// Revision: 1.0 - initial release
// ============================================================================
module fft_8p_p2s_out
  import fft_8p_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter bit BIT_REV = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load,
  input  logic [N_POINTS*DATA_W-1:0] in_re,
  input  logic [N_POINTS*DATA_W-1:0] in_im,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_re,
  output logic [DATA_W-1:0]          out_im,
  output logic [IDX_W-1:0]           out_idx,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done,
  output logic                       overrun,
  input  logic                       clr_err
);

  localparam logic [IDX_W-1:0] C_LAST_K = IDX_W'(N_POINTS - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IDX_W-1:0]    r_k;
  logic [DATA_W-1:0]   r_buf_re [N_POINTS];
  logic [DATA_W-1:0]   r_buf_im [N_POINTS];
  logic [DATA_W-1:0]   r_out_re;
  logic [DATA_W-1:0]   r_out_im;
  logic                r_done;
  logic                r_overrun;

  logic [DATA_W-1:0]   w_in_re [N_POINTS];
  logic [DATA_W-1:0]   w_in_im [N_POINTS];
  logic                w_stream;
  logic                w_hs;
  logic                w_last_hs;
  logic                w_capture;
  logic                w_ovr_evt;
  logic                w_advance;
  logic [IDX_W-1:0]    w_k_nxt;
  logic [IDX_W-1:0]    w_slot_nxt;

  function automatic logic [IDX_W-1:0] slot_of(input logic [IDX_W-1:0] k);
    return BIT_REV ? bitrev3(k) : k;
  endfunction

  generate
    for (genvar j = 0; j < N_POINTS; j++) begin : g_unpack
      assign w_in_re[j] = in_re[j*DATA_W +: DATA_W];
      assign w_in_im[j] = in_im[j*DATA_W +: DATA_W];
    end
  endgenerate

  assign w_stream  = (r_state == STREAM);
  assign w_hs      = w_stream && out_ready;
  assign w_last_hs = w_hs && (r_k == C_LAST_K);
  // A load is accepted when idle, or when it coincides with the final
  // handshake (back-to-back frames). Any other load while streaming is an
  // overrun and is dropped.
  assign w_capture = load && (!w_stream || w_last_hs);
  assign w_ovr_evt = load && w_stream && !w_last_hs;
  assign w_advance = w_hs && !w_last_hs;
  assign w_k_nxt    = r_k + IDX_W'(1);
  assign w_slot_nxt = slot_of(w_k_nxt);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (load) begin
          w_state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (w_last_hs && !load) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Frame buffer (contents are don't-care after reset, so no reset here)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_capture) begin
      for (int j = 0; j < N_POINTS; j++) begin
        r_buf_re[j] <= w_in_re[j];
        r_buf_im[j] <= w_in_im[j];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Beat counter, registered output data and status flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_k       <= '0;
      r_out_re  <= '0;
      r_out_im  <= '0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_done <= w_last_hs;

      if (w_ovr_evt) begin
        r_overrun <= 1'b1;
      end else if (clr_err) begin
        r_overrun <= 1'b0;
      end

      if (w_capture) begin
        // Beat 0 maps to slot 0 in both orderings, so it is taken straight
        // from the input bus rather than the buffer being written.
        r_k      <= '0;
        r_out_re <= w_in_re[0];
        r_out_im <= w_in_im[0];
      end else if (w_advance) begin
        r_k      <= w_k_nxt;
        r_out_re <= r_buf_re[w_slot_nxt];
        r_out_im <= r_buf_im[w_slot_nxt];
      end
    end
  end

  assign out_valid = w_stream;
  assign busy      = w_stream;
  assign out_last  = w_stream && (r_k == C_LAST_K);
  assign out_idx   = r_k;
  assign out_re    = r_out_re;
  assign out_im    = r_out_im;
  assign done      = r_done;
  assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_fft_8p_p2s_out.sv
`default_nettype none
// ============================================================================
// Module  : tb_fft_8p_p2s_out
// Purpose : Self-checking bench for fft_8p_p2s_out. Two instances (natural
//           and bit-reversed order) share one stimulus stream and are
//           compared every cycle against a frame-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fft_8p_p2s_out;

  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic load = 1'b0;
  logic out_ready = 1'b0;
  logic clr_err = 1'b0;
  logic [8*DW-1:0] in_re = '0;
  logic [8*DW-1:0] in_im = '0;

  logic          v0, v1, l0, l1, b0, b1, d0, d1, o0, o1;
  logic [DW-1:0] re0, re1, im0, im1;
  logic [2:0]    idx0, idx1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fft_8p_p2s_out #(.DATA_W(DW), .BIT_REV(1'b0)) dut0 (
    .clk(clk), .reset(reset), .load(load), .in_re(in_re), .in_im(in_im),
    .out_ready(out_ready), .out_valid(v0), .out_re(re0), .out_im(im0),
    .out_idx(idx0), .out_last(l0), .busy(b0), .done(d0), .overrun(o0),
    .clr_err(clr_err));

  fft_8p_p2s_out #(.DATA_W(DW), .BIT_REV(1'b1)) dut1 (
    .clk(clk), .reset(reset), .load(load), .in_re(in_re), .in_im(in_im),
    .out_ready(out_ready), .out_valid(v1), .out_re(re1), .out_im(im1),
    .out_idx(idx1), .out_last(l1), .busy(b1), .done(d1), .overrun(o1),
    .clr_err(clr_err));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int brev(input int k);
    return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
  endfunction

  // --------------------------------------------------------------------------
  // Reference model: one frame held as an array, a beat number and flags.
  // --------------------------------------------------------------------------
  bit            m_active = 1'b0;
  int            m_k = 0;
  logic [DW-1:0] m_fre [8];
  logic [DW-1:0] m_fim [8];
  bit            m_done = 1'b0;
  bit            m_ovr = 1'b0;
  bit            m_hs, m_last, m_evt;

  task automatic model_clear();
    m_active = 1'b0;
    m_k      = 0;
    m_done   = 1'b0;
    m_ovr    = 1'b0;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      model_clear();
    end else begin
      m_hs   = m_active && out_ready;
      m_last = m_hs && (m_k == 7);
      m_evt  = load && m_active && !m_last;
      m_done = m_last;
      if (m_evt) m_ovr = 1'b1;
      else if (clr_err) m_ovr = 1'b0;
      if (load && (!m_active || m_last)) begin
        for (int j = 0; j < 8; j++) begin
          m_fre[j] = in_re[j*DW +: DW];
          m_fim[j] = in_im[j*DW +: DW];
        end
        m_k      = 0;
        m_active = 1'b1;
      end else if (m_last) begin
        m_active = 1'b0;
      end else if (m_hs) begin
        m_k = m_k + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      model_clear();
      chk("rst_valid0", v0, 0);   chk("rst_valid1", v1, 0);
      chk("rst_busy0", b0, 0);    chk("rst_busy1", b1, 0);
      chk("rst_done0", d0, 0);    chk("rst_done1", d1, 0);
      chk("rst_ovr0", o0, 0);     chk("rst_ovr1", o1, 0);
      chk("rst_last0", l0, 0);    chk("rst_last1", l1, 0);
      chk("rst_re0", re0, 0);     chk("rst_im0", im0, 0);
      chk("rst_idx0", idx0, 0);   chk("rst_idx1", idx1, 0);
    end else begin
      chk("m_valid0", v0, m_active);  chk("m_valid1", v1, m_active);
      chk("m_busy0", b0, m_active);   chk("m_busy1", b1, m_active);
      chk("m_done0", d0, m_done);     chk("m_done1", d1, m_done);
      chk("m_ovr0", o0, m_ovr);       chk("m_ovr1", o1, m_ovr);
      chk("m_last0", l0, m_active && m_k == 7);
      chk("m_last1", l1, m_active && m_k == 7);
      if (m_active) begin
        chk("m_idx0", idx0, m_k);            chk("m_idx1", idx1, m_k);
        chk("m_re0", re0, m_fre[m_k]);       chk("m_im0", im0, m_fim[m_k]);
        chk("m_re1", re1, m_fre[brev(m_k)]); chk("m_im1", im1, m_fim[brev(m_k)]);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (inputs change 2 time units after the rising edge)
  // --------------------------------------------------------------------------
  task automatic set_frame(input int rb, input int rs, input int ib, input int is);
    for (int j = 0; j < 8; j++) begin
      in_re[j*DW +: DW] = 16'(rb + rs*j);
      in_im[j*DW +: DW] = 16'(ib + is*j);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_load();
    load = 1'b1;
    next_cycle();
    load = 1'b0;
  endtask

  task automatic wait_k(input int kk);
    int t = 0;
    while (!(m_active && m_k == kk) && t < 40) begin
      next_cycle();
      t++;
    end
    chk("wait_k_bound", 32'(m_active && m_k == kk), 1);
  endtask

  typedef struct {
    logic          valid;
    logic [DW-1:0] re_nat;
    logic [DW-1:0] re_rev;
    logic [DW-1:0] im;
    logic [2:0]    idx;
    logic          last;
    logic          done;
    logic          busy;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    // Expected per-cycle results after a load of re=16*j, im=-j, ready=1.
    for (int i = 0; i < 8; i++) begin
      tbl[i].valid  = 1'b1;
      tbl[i].re_nat = 16'(16*i);
      tbl[i].re_rev = 16'(16*brev(i));
      tbl[i].im     = 16'(-i);
      tbl[i].idx    = 3'(i);
      tbl[i].last   = (i == 7);
      tbl[i].done   = 1'b0;
      tbl[i].busy   = 1'b1;
    end
    tbl[8] = '{valid: 1'b0, re_nat: '0, re_rev: '0, im: '0, idx: '0,
               last: 1'b0, done: 1'b1, busy: 1'b0};

    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", v0, 0);

    // Basic frame, both orderings, table-driven
    next_cycle();
    out_ready = 1'b1;
    set_frame(0, 16, 0, -1);
    pulse_load();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("tbl_valid", v0, tbl[i].valid);
      chk("tbl_done", d0, tbl[i].done);
      chk("tbl_busy", b0, tbl[i].busy);
      chk("tbl_last", l0, tbl[i].last);
      chk("tbl_rev_done", d1, tbl[i].done);
      if (tbl[i].valid) begin
        chk("tbl_re_nat", re0, tbl[i].re_nat);
        chk("tbl_re_rev", re1, tbl[i].re_rev);
        chk("tbl_im", im0, tbl[i].im);
        chk("tbl_idx", idx0, tbl[i].idx);
        chk("tbl_idx_rev", idx1, tbl[i].idx);
      end
    end

    // Backpressure at k=2 and k=7
    next_cycle();
    set_frame(0, 16, 0, -1);
    pulse_load();
    wait_k(2);
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold_re_k2", re0, 32);
      chk("bp_hold_idx_k2", idx0, 2);
      next_cycle();
    end
    out_ready = 1'b1;
    wait_k(7);
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold_re_k7", re0, 112);
      chk("bp_hold_done_k7", d0, 0);
      next_cycle();
    end
    out_ready = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("bp_done_late", d0, 1);

    // Back-to-back frames
    next_cycle();
    set_frame(0, 16, 0, -1);
    pulse_load();
    wait_k(7);
    set_frame(1000, 1, 7, 3);
    pulse_load();
    @(negedge clk);
    chk("b2b_valid", v0, 1);
    chk("b2b_re", re0, 1000);
    chk("b2b_idx", idx0, 0);
    chk("b2b_done", d0, 1);
    chk("b2b_ovr", o0, 0);
    repeat (10) next_cycle();

    // Overrun, clear, and set-wins-over-clear
    set_frame(0, 16, 0, -1);
    pulse_load();
    wait_k(3);
    set_frame(5000, 1, 5000, 1);
    pulse_load();
    @(negedge clk);
    chk("ovr_set", o0, 1);
    chk("ovr_orig_data", re0, 64);
    repeat (8) next_cycle();
    @(negedge clk);
    chk("ovr_sticky", o0, 1);
    clr_err = 1'b1;
    next_cycle();
    clr_err = 1'b0;
    @(negedge clk);
    chk("ovr_cleared", o0, 0);
    set_frame(-100, 3, 9, -2);
    pulse_load();
    wait_k(2);
    load = 1'b1;
    clr_err = 1'b1;
    next_cycle();
    load = 1'b0;
    clr_err = 1'b0;
    @(negedge clk);
    chk("ovr_set_wins", o0, 1);
    repeat (8) next_cycle();
    clr_err = 1'b1;
    next_cycle();
    clr_err = 1'b0;

    // Asynchronous reset in mid-stream
    set_frame(0, 16, 0, -1);
    pulse_load();
    wait_k(4);
    reset = 1'b1;
    #1;
    chk("arst_valid", v0, 0);
    chk("arst_busy", b0, 0);
    chk("arst_done", d0, 0);
    chk("arst_valid_rev", v1, 0);
    next_cycle();
    reset = 1'b0;
    repeat (3) next_cycle();
    @(negedge clk);
    chk("arst_stays_idle", v0, 0);
    set_frame(200, 5, -50, 4);
    pulse_load();
    @(negedge clk);
    chk("arst_new_idx", idx0, 0);
    chk("arst_new_re", re0, 200);
    repeat (10) next_cycle();

    // Randomized traffic against the model
    for (int c = 0; c < 2000; c++) begin
      out_ready = ($urandom % 4) != 0;
      if (m_active && m_k == 7 && out_ready) load = ($urandom % 2) == 0;
      else load = ($urandom % 12) == 0;
      if (load) begin
        for (int j = 0; j < 8; j++) begin
          in_re[j*DW +: DW] = 16'($urandom);
          in_im[j*DW +: DW] = 16'($urandom);
        end
      end
      clr_err = ($urandom % 16) == 0;
      reset = ($urandom % 250) == 0;
      next_cycle();
    end
    load = 1'b0;
    clr_err = 1'b0;
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (12) next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
